// File: rtl/pid_channel_scheduler.sv
// rtl/pid_channel_scheduler.sv - sample-tick scheduler sharing one PID core across NCH channels
// Optional core-timeout watchdog: define PID_SCHED_TIMEOUT_EN.
module pid_channel_scheduler #(
    parameter int NCH     = 4,
    parameter int W       = 8,
    parameter int DIV     = 50,
    parameter int TIMEOUT = 16,
    localparam int AW     = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [W-1:0]      cfg_wdata,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*W-1:0]  meas_bus,
    output logic              pid_start,
    output logic [AW-1:0]     pid_ch,
    output logic [W-1:0]      pid_ref,
    output logic [W-1:0]      pid_meas,
    input  logic              pid_done,
    input  logic [W-1:0]      pid_out,
    output logic [NCH*W-1:0]  ctrl_bus,
    output logic [NCH-1:0]    ctrl_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);
    localparam int CW = $clog2(DIV);
    localparam int TW = $clog2(TIMEOUT) + 1;
`ifdef PID_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;
    state_t state, state_n;

    logic [CW-1:0]    tcnt;
    logic             tick;
    logic [NCH-1:0]   pending;
    logic [NCH*W-1:0] snap;
    logic [W-1:0]     ref_r [NCH];
    logic [AW-1:0]    cur_q, cur_sel;
    logic [W-1:0]     ref_q, meas_q;
    logic [TW-1:0]    wcnt;
    logic [NCH-1:0]   cur_mask;
    logic             timeout_hit;

    assign tick     = (tcnt == CW'(DIV - 1));
    assign cur_mask = {{(NCH-1){1'b0}}, 1'b1} << cur_q;
    assign timeout_hit = TO_EN && (state == WAIT) && !pid_done && (wcnt == TW'(TIMEOUT - 1));

    // Lowest pending channel wins.
    always_comb begin
        cur_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) cur_sel = AW'(i);
        end
    end

    assign pid_start = (state == ISSUE);
    assign pid_ch    = (state == ISSUE) ? cur_sel : cur_q;
    assign pid_ref   = (state == ISSUE) ? ref_r[cur_sel] : ref_q;
    assign pid_meas  = (state == ISSUE) ? snap[cur_sel*W +: W] : meas_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (tick && (ch_en != '0)) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (pid_done || timeout_hit) state_n = STORE;
            STORE:   state_n = ((pending & ~cur_mask) != '0) ? ISSUE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending     <= '0;
            snap        <= '0;
            cur_q       <= '0;
            ref_q       <= '0;
            meas_q      <= '0;
            wcnt        <= '0;
            ctrl_bus    <= '0;
            ctrl_valid  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NCH; i++) ref_r[i] <= '0;
        end else begin
            ctrl_valid <= '0;
            if (cfg_we && (int'(cfg_addr) < NCH)) ref_r[cfg_addr] <= cfg_wdata;
            if (tick && (state != IDLE)) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        pending <= ch_en;
                        snap    <= meas_bus;
                    end
                end
                ISSUE: begin
                    // Operands are frozen here so later ref writes cannot disturb the core.
                    cur_q  <= cur_sel;
                    ref_q  <= ref_r[cur_sel];
                    meas_q <= snap[cur_sel*W +: W];
                    wcnt   <= '0;
                end
                WAIT: begin
                    wcnt <= wcnt + TW'(1);
                    if (pid_done) begin
                        ctrl_bus[cur_q*W +: W] <= pid_out;
                        ctrl_valid             <= cur_mask;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                STORE: pending <= pending & ~cur_mask;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pid_channel_scheduler.sv
// tb/tb_pid_channel_scheduler.sv - self-checking bench for pid_channel_scheduler
module tb_pid_channel_scheduler;
    localparam int NCH = 4, W = 8, DIV = 50, TIMEOUT = 16, AW = 2;
`ifdef PID_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0] cfg_wdata = '0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH*W-1:0] meas_bus = '0;
    logic pid_start, pid_done, busy, overrun, timeout_err;
    logic [AW-1:0] pid_ch;
    logic [W-1:0] pid_ref, pid_meas, pid_out;
    logic [NCH*W-1:0] ctrl_bus;
    logic [NCH-1:0] ctrl_valid;

    always #5 clk = ~clk;

    pid_channel_scheduler #(.NCH(NCH), .W(W), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .ch_en(ch_en), .meas_bus(meas_bus), .pid_start(pid_start), .pid_ch(pid_ch),
        .pid_ref(pid_ref), .pid_meas(pid_meas), .pid_done(pid_done), .pid_out(pid_out),
        .ctrl_bus(ctrl_bus), .ctrl_valid(ctrl_valid), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    int errors = 0;
    int checks = 0;

    // Model: event times derived from the tick period and the observed core handshake.
    bit mvalid = 0;
    int n = 0;
    logic [W-1:0] ref_m [NCH];
    logic [W-1:0] ctrl_m [NCH];
    logic [W-1:0] snap_m [NCH];
    int q[$];
    int start_at = -1;
    bit waiting = 0;
    int cur = 0, start_cyc = 0;
    logic [W-1:0] exp_ref, exp_meas;
    logic [NCH-1:0] valid_m = '0;
    bit busy_m = 0, ovr_m = 0, to_m = 0, post_reset = 0;
    bit tick_m, store_next;

    // DUT activity logs for the literal checks.
    int starts[$];
    logic [W-1:0] start_refs[$];
    logic [W-1:0] start_meas[$];
    logic [NCH-1:0] valids[$];

    // Behavioural PID core stand-in: answers ref-meas lat cycles after start.
    int lat = 2;
    int noans = -1;
    int pend = 0;
    logic [W-1:0] pend_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic logic [NCH*W-1:0] pack_ctrl();
        logic [NCH*W-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*W +: W] = ctrl_m[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mvalid = 1; n = 0; q = {}; start_at = -1; waiting = 0;
            valid_m = '0; busy_m = 0; ovr_m = 0; to_m = 0; post_reset = 1;
            for (int i = 0; i < NCH; i++) begin ref_m[i] = '0; ctrl_m[i] = '0; snap_m[i] = '0; end
        end else if (mvalid) begin
            tick_m = ((n % DIV) == DIV - 1);
            store_next = 0;
            valid_m = '0;
            if (waiting) begin
                if (pid_done) begin
                    ctrl_m[cur] = pid_out; valid_m[cur] = 1'b1; store_next = 1;
                end else if (TO_EN && (n - start_cyc == TIMEOUT)) begin
                    to_m = 1; store_next = 1;
                end
                if (store_next) begin
                    waiting = 0;
                    void'(q.pop_front());
                    if (q.size() > 0) start_at = n + 2;
                end
            end
            if (n == start_at) begin
                cur = q[0]; waiting = 1; start_cyc = n; start_at = -1; post_reset = 0;
                exp_ref = ref_m[cur]; exp_meas = snap_m[cur];
            end
            if (tick_m) begin
                if (busy_m) ovr_m = 1;
                else if (ch_en != '0) begin
                    q = {};
                    for (int i = 0; i < NCH; i++) begin
                        snap_m[i] = meas_bus[i*W +: W];
                        if (ch_en[i]) q.push_back(i);
                    end
                    start_at = n + 1;
                end
            end
            if (cfg_we && int'(cfg_addr) < NCH) ref_m[cfg_addr] = cfg_wdata;
            busy_m = (q.size() > 0) || store_next;
            n++;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("pid_start", pid_start, n == start_at);
            if (n == start_at) begin
                chk("pid_ch@start", pid_ch, q[0]);
                chk("pid_ref@start", pid_ref, ref_m[q[0]]);
                chk("pid_meas@start", pid_meas, snap_m[q[0]]);
            end else if (waiting) begin
                chk("pid_ch@wait", pid_ch, cur);
                chk("pid_ref@wait", pid_ref, exp_ref);
                chk("pid_meas@wait", pid_meas, exp_meas);
            end else if (post_reset) begin
                chk("pid_opnds@reset", {pid_ch, pid_ref, pid_meas}, 0);
            end
            chk("ctrl_valid", ctrl_valid, valid_m);
            chk("ctrl_bus", ctrl_bus, pack_ctrl());
            chk("busy", busy, busy_m);
            chk("overrun", overrun, ovr_m);
            chk("timeout_err", timeout_err, to_m);
            if (pid_start === 1'b1) begin
                starts.push_back(int'(pid_ch)); start_refs.push_back(pid_ref); start_meas.push_back(pid_meas);
            end
            if (ctrl_valid !== '0) valids.push_back(ctrl_valid);
        end
    end

    initial begin
        pid_done = 1'b0;
        pid_out  = '0;
        forever begin
            @(negedge clk);
            pid_done = 1'b0;
            if (busy !== 1'b1) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) begin pid_done = 1'b1; pid_out = pend_val; end
            end
            if (pid_start === 1'b1 && int'(pid_ch) != noans) begin
                pend = lat; pend_val = pid_ref - pid_meas;
            end
        end
    end

    task automatic cfg_write(input int addr, input logic [W-1:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_starts(input int k, input int budget, input string name);
        int c = 0;
        while (starts.size() < k && c < budget) begin @(negedge clk); c++; end
        chk(name, starts.size() >= k, 1);
    endtask

    task automatic wait_valids(input int k, input int budget, input string name);
        int c = 0;
        while (valids.size() < k && c < budget) begin @(negedge clk); c++; end
        chk(name, valids.size() >= k, 1);
    endtask

    task automatic clear_logs();
        starts = {}; start_refs = {}; start_meas = {}; valids = {};
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // Reset state, nothing enabled
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("t1_no_start", starts.size(), 0);
        chk("t1_ctrl_bus", ctrl_bus, 0);

        // Single channel, ref 2.0, meas 0
        cfg_write(0, 8'd32);
        ch_en = 4'b0001;
        wait_valids(1, 200, "t2_valid_seen");
        ch_en = 4'b0000;
        repeat (3) @(negedge clk);
        chk("t2_start_ch", starts.size() > 0 ? starts[0] : -1, 0);
        chk("t2_start_ref", start_refs.size() > 0 ? start_refs[0] : 8'hxx, 8'd32);
        chk("t2_start_meas", start_meas.size() > 0 ? start_meas[0] : 8'hxx, 8'd0);
        chk("t2_valid", valids[0], 4'b0001);
        chk("t2_ctrl0", ctrl_bus[7:0], 8'd32);

        // Two sparse channels, lowest index first
        clear_logs();
        cfg_write(1, 8'd16);
        cfg_write(3, 8'd48);
        meas_bus = {8'd8, 8'd0, 8'd4, 8'd0};
        ch_en = 4'b1010;
        wait_valids(2, 200, "t3_valids_seen");
        ch_en = 4'b0000;
        repeat (3) @(negedge clk);
        chk("t3_order", {starts[0][7:0], starts[1][7:0]}, {8'd1, 8'd3});
        chk("t3_valid_seq", {valids[0], valids[1]}, {4'b0010, 4'b1000});
        chk("t3_ctrl1", ctrl_bus[15:8], 8'd12);
        chk("t3_ctrl3", ctrl_bus[31:24], 8'd40);
        chk("t3_ctrl0_kept", ctrl_bus[7:0], 8'd32);

        // Core slower than the tick period
        clear_logs();
        lat = 60;
        meas_bus[7:0] = 8'd16;
        ch_en = 4'b0001;
        wait_valids(1, 300, "t4_valid_seen");
        ch_en = 4'b0000;
        repeat (2) @(negedge clk);
        chk("t4_overrun", overrun, 1);
        chk("t4_one_start", starts.size(), 1);
        chk("t4_ctrl0", ctrl_bus[7:0], 8'd16);

        // Reset while waiting on the core
        repeat (60) @(negedge clk);
        clear_logs();
        lat = 30;
        meas_bus = {8'd0, 8'd0, 8'd4, 8'd16};
        ch_en = 4'b0011;
        wait_starts(1, 100, "t5_first_start");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_logs();
        lat = 2;
        wait_starts(1, 100, "t5_restart");
        chk("t5_no_valid", valids.size(), 0);
        chk("t5_restart_ch", starts[0], 0);
        chk("t5_ctrl_cleared", ctrl_bus, 0);
        chk("t5_overrun_cleared", overrun, 0);
        wait_valids(2, 100, "t5_valids_seen");
        ch_en = 4'b0000;
        repeat (3) @(negedge clk);
        chk("t5_ctrl0", ctrl_bus[7:0], 8'hF0);
        chk("t5_ctrl1", ctrl_bus[15:8], 8'hFC);

`ifdef PID_SCHED_TIMEOUT_EN
        // Core never answers channel 0
        repeat (60) @(negedge clk);
        clear_logs();
        noans = 0;
        ch_en = 4'b0011;
        wait_starts(2, 200, "t6_second_start");
        ch_en = 4'b0000;
        chk("t6_timeout_err", timeout_err, 1);
        chk("t6_order", {starts[0][7:0], starts[1][7:0]}, {8'd0, 8'd1});
        chk("t6_ctrl0_held", ctrl_bus[7:0], 8'hF0);
        wait_valids(1, 100, "t6_ch1_valid");
        chk("t6_only_ch1", valids[0], 4'b0010);
        noans = -1;
`endif

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
